// File: rtl/rf_wr_arbiter_pkg.sv
// Shared CPU constants for the register-file write arbiter: register
// number / register width and the arbiter FSM state encodings.
package rf_wr_arbiter_pkg;

    localparam int CPU_REGNO_WIDTH = 5;
    localparam int CPU_REG_WIDTH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/md_res_fifo.sv
// Mul/div result queue. Each entry carries valid/rd/data; a valid bit can be
// cleared in place by rd match so stale results are dropped at the head.
module md_res_fifo
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [CPU_REGNO_WIDTH-1:0] push_rd,
    input  logic [CPU_REG_WIDTH-1:0]   push_data,
    input  logic                       pop,
    input  logic                       inval_en,
    input  logic [CPU_REGNO_WIDTH-1:0] inval_rd,
    output logic                       empty,
    output logic                       full,
    output logic                       head_valid,
    output logic [CPU_REGNO_WIDTH-1:0] head_rd,
    output logic [CPU_REG_WIDTH-1:0]   head_data,
    output logic [CW-1:0]              count
);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [CPU_REGNO_WIDTH-1:0] rd_q   [DEPTH];
    logic [CPU_REGNO_WIDTH-1:0] rd_d   [DEPTH];
    logic [CPU_REG_WIDTH-1:0]   data_q [DEPTH];
    logic [CPU_REG_WIDTH-1:0]   data_d [DEPTH];
    logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       do_pop, do_push;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign head_valid = valid_q[rptr_q] && !empty;
    assign head_rd    = rd_q[rptr_q];
    assign head_data  = data_q[rptr_q];
    assign count      = count_q;

    // Next-state: invalidate, then pop, then push so a push into the slot
    // freed by a same-cycle pop on a full queue lands intact.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        if (inval_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == inval_rd) valid_d[i] = 1'b0;
            end
        end
        if (do_pop) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + 1'b1;
        end
        if (do_push) begin
            valid_d[wptr_q] = 1'b1;
            rd_d[wptr_q]    = push_rd;
            data_d[wptr_q]  = push_data;
            wptr_d          = wptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Queue storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write port arbiter. Writeback wins; queued mul/div results
// fill idle slots, and a starving queue head requests a pipeline stall.
//
// state | meaning
// IDLE  | queue empty
// PEND  | results queued, counting cycles the head is blocked
// FORCE | head starved, stall requested until a pop
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int MD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_core_stall,
    input  logic [CPU_REGNO_WIDTH-1:0] i_wb_rd,
    input  logic [CPU_REG_WIDTH-1:0]   i_wb_rd_data,
    input  logic                       i_md_valid,
    input  logic [CPU_REGNO_WIDTH-1:0] i_md_rd,
    input  logic [CPU_REG_WIDTH-1:0]   i_md_data,
    output logic                       o_md_ready,
    output logic                       o_rf_we,
    output logic [CPU_REGNO_WIDTH-1:0] o_rf_rd,
    output logic [CPU_REG_WIDTH-1:0]   o_rf_data,
    output logic                       o_stall_req
);

    localparam int CW = $clog2(MD_DEPTH) + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    arb_state_e                 state_q, state_d;
    logic [WW-1:0]              wait_q, wait_d;
    logic                       rf_we_q, rf_we_d;
    logic [CPU_REGNO_WIDTH-1:0] rf_rd_q, rf_rd_d;
    logic [CPU_REG_WIDTH-1:0]   rf_data_q, rf_data_d;
    logic                       stall_req_q, stall_req_d;

    logic                       wb_win, pop, push, bypass, md_grant, md_ready;
    logic                       q_empty, q_full, q_head_valid;
    logic [CPU_REGNO_WIDTH-1:0] q_head_rd;
    logic [CPU_REG_WIDTH-1:0]   q_head_data;
    logic [CW-1:0]              q_count, cnt_next;

    md_res_fifo #(.DEPTH(MD_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_rd    (i_md_rd),
        .push_data  (i_md_data),
        .pop        (pop),
        .inval_en   (wb_win),
        .inval_rd   (i_wb_rd),
        .empty      (q_empty),
        .full       (q_full),
        .head_valid (q_head_valid),
        .head_rd    (q_head_rd),
        .head_data  (q_head_data),
        .count      (q_count)
    );

    // Grant decision and queue handshake; an empty queue lets an md offer
    // go straight to the write port so it is not delayed a cycle.
    always_comb begin
        wb_win    = (i_wb_rd != '0) && !i_core_stall;
        pop       = !q_empty && (!q_head_valid || !wb_win);
        md_grant  = pop && q_head_valid;
        md_ready  = !rst && (!q_full || pop);
        bypass    = q_empty && !wb_win && i_md_valid && (i_md_rd != '0);
        push      = i_md_valid && md_ready && (i_md_rd != '0) && !bypass;
        cnt_next  = q_count + CW'(push) - CW'(pop);
        rf_we_d   = 1'b0;
        rf_rd_d   = '0;
        rf_data_d = '0;
        if (wb_win) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = i_wb_rd;
            rf_data_d = i_wb_rd_data;
        end else if (md_grant) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = q_head_rd;
            rf_data_d = q_head_data;
        end else if (bypass) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = i_md_rd;
            rf_data_d = i_md_data;
        end
    end

    // Starvation FSM next-state, driven by the queue occupancy after this cycle.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (cnt_next != '0) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (pop) begin
                    wait_d = '0;
                    if (cnt_next == '0) state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if ((wait_q + 1'b1) >= WW'(STARVE_LIMIT)) state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                if (pop) begin
                    wait_d  = '0;
                    state_d = (cnt_next == '0) ? ST_IDLE : ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
        stall_req_d = (state_d == ST_FORCE);
    end

    // Registered write port, stall request and FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_data_q   <= '0;
            stall_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_data_q   <= rf_data_d;
            stall_req_q <= stall_req_d;
        end
    end

    assign o_md_ready  = md_ready;
    assign o_rf_we     = rf_we_q;
    assign o_rf_rd     = rf_rd_q;
    assign o_rf_data   = rf_data_q;
    assign o_stall_req = stall_req_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: a cycle model predicts each write-port value and
// queues it; a monitor pops and compares one entry after every clock edge.
module tb_rf_wr_arbiter;
    import rf_wr_arbiter_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic                       we;
        logic [CPU_REGNO_WIDTH-1:0] rd;
        logic [CPU_REG_WIDTH-1:0]   data;
    } exp_t;

    typedef struct {
        logic                       v;
        logic [CPU_REGNO_WIDTH-1:0] rd;
        logic [CPU_REG_WIDTH-1:0]   d;
    } ent_t;

    logic                       clk;
    logic                       rst;
    logic                       i_core_stall;
    logic [CPU_REGNO_WIDTH-1:0] i_wb_rd;
    logic [CPU_REG_WIDTH-1:0]   i_wb_rd_data;
    logic                       i_md_valid;
    logic [CPU_REGNO_WIDTH-1:0] i_md_rd;
    logic [CPU_REG_WIDTH-1:0]   i_md_data;
    logic                       o_md_ready;
    logic                       o_rf_we;
    logic [CPU_REGNO_WIDTH-1:0] o_rf_rd;
    logic [CPU_REG_WIDTH-1:0]   o_rf_data;
    logic                       o_stall_req;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    ent_t mq[$];
    exp_t mon_e;
    logic last_ready;

    rf_wr_arbiter #(.MD_DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_core_stall (i_core_stall),
        .i_wb_rd      (i_wb_rd),
        .i_wb_rd_data (i_wb_rd_data),
        .i_md_valid   (i_md_valid),
        .i_md_rd      (i_md_rd),
        .i_md_data    (i_md_data),
        .o_md_ready   (o_md_ready),
        .o_rf_we      (o_rf_we),
        .o_rf_rd      (o_rf_rd),
        .o_rf_data    (o_rf_data),
        .o_stall_req  (o_stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: one predicted write-port value per modelled cycle.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (o_rf_we !== mon_e.we ||
                (mon_e.we && (o_rf_rd !== mon_e.rd || o_rf_data !== mon_e.data))) begin
                n_errors++;
                $display("FAIL sb_write: got we=%0b rd=%0d data=%h, expected we=%0b rd=%0d data=%h",
                         o_rf_we, o_rf_rd, o_rf_data, mon_e.we, mon_e.rd, mon_e.data);
            end
        end
    end

    // Drive one cycle, predict the write-port result and queue it.
    task automatic step(input logic stall, input logic [4:0] wrd, input logic [31:0] wdata,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
        exp_t e;
        ent_t n;
        logic wb_win, popped, byp, rdy;
        int   sz;
        i_core_stall = stall;
        i_wb_rd      = wrd;
        i_wb_rd_data = wdata;
        i_md_valid   = mv;
        i_md_rd      = mrd;
        i_md_data    = mdata;
        #1;
        last_ready = o_md_ready;
        wb_win = (wrd != 0) && !stall;
        popped = 1'b0;
        byp    = 1'b0;
        sz     = mq.size();
        e.we = 1'b0; e.rd = '0; e.data = '0;
        if (wb_win) begin
            e.we = 1'b1; e.rd = wrd; e.data = wdata;
            if (sz > 0 && !mq[0].v) begin
                void'(mq.pop_front());
                popped = 1'b1;
            end
        end else if (sz > 0) begin
            if (mq[0].v) begin
                e.we = 1'b1; e.rd = mq[0].rd; e.data = mq[0].d;
            end
            void'(mq.pop_front());
            popped = 1'b1;
        end else if (mv && mrd != 0) begin
            e.we = 1'b1; e.rd = mrd; e.data = mdata;
            byp = 1'b1;
        end
        if (wb_win) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].rd == wrd) mq[i].v = 1'b0;
            end
        end
        rdy = (sz < DEPTH) || popped;
        if (mv && rdy && mrd != 0 && !byp) begin
            n.v = 1'b1; n.rd = mrd; n.d = mdata;
            mq.push_back(n);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o_rf_we !== 1'b0 || o_rf_rd !== 5'd0 || o_rf_data !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_rf: got we=%0b rd=%0d data=%h, expected 0", o_rf_we, o_rf_rd, o_rf_data);
        end
        n_checks++;
        if (o_stall_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_stall: got %0b, expected 0", o_stall_req);
        end
        n_checks++;
        if (o_md_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready: got %0b, expected 0", o_md_ready);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (o_md_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %0b, expected 1", o_md_ready);
        end
    endtask

    task automatic test_bypass();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        n_checks++;
        if (o_rf_we !== 1'b1 || o_rf_rd !== 5'd5 || o_rf_data !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL bypass_latency: got we=%0b rd=%0d data=%h, expected we=1 rd=5 data=deadbeef",
                     o_rf_we, o_rf_rd, o_rf_data);
        end
        idle();
    endtask

    task automatic test_starve();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 5'd3, 32'h300 + i, (i == 0), 5'd7, 32'h7777);
            n_checks++;
            if (o_stall_req !== (i == 4)) begin
                n_errors++;
                $display("FAIL starve_stall_%0d: got %0b, expected %0b", i, o_stall_req, (i == 4));
            end
        end
        step(1'b1, 5'd3, 32'h399, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (o_rf_we !== 1'b1 || o_rf_rd !== 5'd7 || o_stall_req !== 1'b0) begin
            n_errors++;
            $display("FAIL starve_release: got we=%0b rd=%0d stall=%0b, expected we=1 rd=7 stall=0",
                     o_rf_we, o_rf_rd, o_stall_req);
        end
        idle();
    endtask

    task automatic test_invalidate();
        step(1'b0, 5'd3, 32'h31, 1'b1, 5'd9, 32'h99);
        step(1'b0, 5'd9, 32'h11, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            idle();
            n_checks++;
            if (o_rf_we !== 1'b0) begin
                n_errors++;
                $display("FAIL inval_no_write_%0d: got we=%0b rd=%0d, expected we=0", i, o_rf_we, o_rf_rd);
            end
        end
    endtask

    task automatic test_full();
        step(1'b0, 5'd3, 32'hA0, 1'b1, 5'd10, 32'h1010);
        step(1'b0, 5'd3, 32'hA1, 1'b1, 5'd11, 32'h1111);
        step(1'b0, 5'd3, 32'hA2, 1'b1, 5'd12, 32'h1212);
        n_checks++;
        if (last_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_ready_low: got %0b, expected 0", last_ready);
        end
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1212);
        n_checks++;
        if (last_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL full_pop_ready: got %0b, expected 1", last_ready);
        end
        repeat (3) idle();
    endtask

    task automatic test_same_rd();
        step(1'b0, 5'd4, 32'h44, 1'b1, 5'd4, 32'h55);
        idle();
        n_checks++;
        if (o_rf_we !== 1'b1 || o_rf_rd !== 5'd4 || o_rf_data !== 32'h55) begin
            n_errors++;
            $display("FAIL same_rd_md_kept: got we=%0b rd=%0d data=%h, expected we=1 rd=4 data=55",
                     o_rf_we, o_rf_rd, o_rf_data);
        end
    endtask

    task automatic test_rd_zero();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hAB);
        n_checks++;
        if (last_ready !== 1'b1 || o_rf_we !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_zero_discard: got ready=%0b we=%0b, expected ready=1 we=0", last_ready, o_rf_we);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        step(1'b0, 5'd3, 32'hB0, 1'b1, 5'd20, 32'h2020);
        step(1'b0, 5'd3, 32'hB1, 1'b1, 5'd21, 32'h2121);
        rst = 1'b1;
        i_wb_rd = '0; i_md_valid = 1'b0; i_core_stall = 1'b0;
        mq.delete();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (o_rf_we !== 1'b0 || o_rf_rd !== 5'd0 || o_rf_data !== 32'd0 ||
                o_stall_req !== 1'b0 || o_md_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid_%0d: got we=%0b rd=%0d data=%h stall=%0b ready=%0b, expected all 0",
                         i, o_rf_we, o_rf_rd, o_rf_data, o_stall_req, o_md_ready);
            end
            @(posedge clk);
            #1;
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (o_md_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_ready: got %0b, expected 1", o_md_ready);
        end
        repeat (3) idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
        end
        repeat (4) idle();
    endtask

    initial begin
        rst          = 1'b1;
        i_core_stall = 1'b0;
        i_wb_rd      = '0;
        i_wb_rd_data = '0;
        i_md_valid   = 1'b0;
        i_md_rd      = '0;
        i_md_data    = '0;
        last_ready   = 1'b0;
        test_reset();
        test_bypass();
        test_starve();
        test_invalidate();
        test_full();
        test_same_rd();
        test_rd_zero();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
